ifetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the byte-wide instruction RAM (iram).
- Drives the iram AHB-style address/control bus as a read-only master and captures the registered byte returned the cycle after each address.
- Assembles little-endian multi-byte instructions and presents them, with their PC, to decode through a valid/ready FIFO.
- Handles branch redirects by flushing all fetched and in-flight data.

---
 rtl/ifetch_unit.sv | 165 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: byte-serial instruction fetch in front of the byte-wide iram.
// Issues one read per cycle on an AHB-style bus, assembles little-endian
// INSN_BYTES-wide instructions and queues them with their PC for decode.
// A redirect flushes everything fetched or in flight and restarts at the new PC.
// Optional build macro IFETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky
// align_fault and stop fetching until an aligned redirect or reset.
module ifetch_unit #(
    parameter int          ADDR_W     = 17,
    parameter int          INSN_BYTES = 2,
    parameter int unsigned RESET_PC   = 0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    output logic [ADDR_W-1:0]       HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [16:0]             HWDATA,
    input  logic [16:0]             HRDATA,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    insn_valid,
    output logic [8*INSN_BYTES-1:0] insn_data,
    output logic [ADDR_W-1:0]       insn_pc,
    input  logic                    insn_ready,
    output logic                    align_fault
);

    localparam int IW    = 8 * INSN_BYTES;
    localparam int IDX_W = (INSN_BYTES > 1) ? $clog2(INSN_BYTES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INSN_BYTES - 1);
    localparam logic [1:0]       TR_IDLE   = 2'b00;
    localparam logic [1:0]       TR_NONSEQ = 2'b10;
    localparam logic [1:0]       TR_SEQ    = 2'b11;

    // Byte position within an instruction, wrapping after the last byte.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // Issue side
    logic [ADDR_W-1:0] fetch_addr;
    logic [IDX_W-1:0]  iss_idx;
    logic [CNT_W-1:0]  pending;     // instructions started but not yet pushed
    // Capture side: vld_p1 marks a byte sampled by iram and due on HRDATA
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [IDX_W-1:0]  cap_idx;
    logic [IW-1:0]     asm_data;
    logic [ADDR_W-1:0] asm_pc;
    // Output FIFO
    logic [ADDR_W+IW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic              redir_bad, redir_ok, halted;
    logic              credit_ok, issue, start, push, pop;
    logic [IW-1:0]     push_data;
    logic [ADDR_W-1:0] push_pc;
    logic              unused_hrdata;

    assign unused_hrdata = ^HRDATA[16:8];
    assign HWRITE        = 1'b0;
    assign HWDATA        = '0;
    assign insn_valid    = (count != '0);
    assign {insn_pc, insn_data} = insn_valid ? fifo_mem[rd_ptr] : '0;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_r;
    assign redir_bad = redirect_valid && ((redirect_pc % ADDR_W'(INSN_BYTES)) != '0);

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge HCLK) begin
        if (HRESET)              fault_r <= 1'b0;
        else if (redirect_valid) fault_r <= redir_bad;
    end

    assign halted      = fault_r;
    assign align_fault = fault_r;
`else
    assign redir_bad   = 1'b0;
    assign halted      = 1'b0;
    assign align_fault = 1'b0;
`endif

    // Credit and event decode; a pop this cycle is deliberately not credited.
    always_comb begin
        credit_ok = ({1'b0, count} + {1'b0, pending}) < (CNT_W+1)'(FIFO_DEPTH);
        issue     = !halted && ((iss_idx != '0) || credit_ok);
        redir_ok  = redirect_valid && !redir_bad;
        start     = redirect_valid ? redir_ok : (issue && (iss_idx == '0));
        push      = vld_p1 && (cap_idx == LAST_IDX) && !redirect_valid;
        pop       = insn_valid && insn_ready;
        push_data = asm_data;
        push_data[IW-8 +: 8] = HRDATA[7:0];
        push_pc   = (cap_idx == '0) ? addr_p1 : asm_pc;
    end

    // Address phase: drive HADDR/HTRANS for the byte issued next cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR      <= ADDR_W'(RESET_PC);
            HTRANS     <= TR_IDLE;
            fetch_addr <= ADDR_W'(RESET_PC);
            iss_idx    <= '0;
        end else if (redirect_valid) begin
            iss_idx <= '0;
            if (redir_bad) begin
                HTRANS     <= TR_IDLE;
                fetch_addr <= redirect_pc;
            end else begin
                HADDR      <= redirect_pc;
                HTRANS     <= TR_NONSEQ;
                fetch_addr <= redirect_pc + ADDR_W'(1);
                iss_idx    <= idx_next('0);
            end
        end else if (issue) begin
            HADDR      <= fetch_addr;
            HTRANS     <= (HTRANS != TR_IDLE) ? TR_SEQ : TR_NONSEQ;
            fetch_addr <= fetch_addr + ADDR_W'(1);
            iss_idx    <= idx_next(iss_idx);
        end else begin
            HTRANS <= TR_IDLE;
        end
    end

    // Control: in-flight kill, capture position, reservation and FIFO occupancy.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            vld_p1  <= 1'b0;
            cap_idx <= '0;
            pending <= '0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else if (redirect_valid) begin
            vld_p1  <= 1'b0;
            cap_idx <= '0;
            pending <= CNT_W'(redir_ok);
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            vld_p1  <= (HTRANS != TR_IDLE);
            if (vld_p1) cap_idx <= idx_next(cap_idx);
            pending <= pending + CNT_W'(start) - CNT_W'(push);
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Datapath: address pipeline, byte assembly and FIFO storage.
    always_ff @(posedge HCLK) begin
        addr_p1 <= HADDR;
        if (vld_p1) begin
            asm_data[8*cap_idx +: 8] <= HRDATA[7:0];
            if (cap_idx == '0) asm_pc <= addr_p1;
        end
        if (push) fifo_mem[wr_ptr] <= {push_pc, push_data};
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream (expected PC sequence, iram image).
module tb_ifetch_unit;

    localparam int ADDR_W = 17;
    localparam int INSN_BYTES = 2;
    localparam int FIFO_DEPTH = 2;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [16:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [16:0] HWDATA;
    logic [16:0] HRDATA = '0;
    logic        redirect_valid = 1'b0;
    logic [16:0] redirect_pc = '0;
    logic        insn_valid;
    logic [15:0] insn_data;
    logic [16:0] insn_pc;
    logic        insn_ready = 1'b0;
    logic        align_fault;

    logic [7:0] iram [0:131071];
    int n_vec = 0;
    int n_err = 0;

    ifetch_unit #(.ADDR_W(ADDR_W), .INSN_BYTES(INSN_BYTES), .RESET_PC(0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .insn_valid(insn_valid), .insn_data(insn_data),
        .insn_pc(insn_pc), .insn_ready(insn_ready), .align_fault(align_fault)
    );

    always #5 HCLK = ~HCLK;

    // iram: samples HADDR at each edge, presents the byte after that edge
    always @(posedge HCLK) HRDATA <= {9'd0, iram[HADDR]};

    task automatic tick();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    function automatic logic [15:0] exp_word(input logic [16:0] pc);
        logic [16:0] pc1;
        pc1 = pc + 17'd1;
        return {iram[pc1], iram[pc]};
    endfunction

    task automatic apply_reset();
        HRESET = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        insn_ready = 1'b0;
        tick();
        tick();
        n_vec++; if (HADDR !== 17'd0) begin n_err++; $display("FAIL reset_haddr got=%h exp=%h", HADDR, 17'd0); end
        n_vec++; if (HTRANS !== T_IDLE) begin n_err++; $display("FAIL reset_htrans got=%b exp=%b", HTRANS, T_IDLE); end
        n_vec++; if (HWRITE !== 1'b0) begin n_err++; $display("FAIL reset_hwrite got=%b exp=0", HWRITE); end
        n_vec++; if (HWDATA !== 17'd0) begin n_err++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA); end
        n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", insn_valid); end
        n_vec++; if (align_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", align_fault); end
    endtask

    task automatic test_basic();
        logic [1:0]  et [6];
        logic [16:0] ea [6];
        logic        ev [6];
        logic [16:0] ep [6];
        logic [15:0] ed [6];
        et = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE, T_NONSEQ};
        ea = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd3, 17'd4};
        ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ep = '{17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd2};
        ed = '{16'h0, 16'h0, 16'h0, 16'h2211, 16'h0, 16'h4433};
        apply_reset();
        insn_ready = 1'b1;
        HRESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++; if (HTRANS !== et[k]) begin n_err++; $display("FAIL basic_htrans[%0d] got=%b exp=%b", k, HTRANS, et[k]); end
            n_vec++; if (HADDR !== ea[k]) begin n_err++; $display("FAIL basic_haddr[%0d] got=%h exp=%h", k, HADDR, ea[k]); end
            n_vec++; if (insn_valid !== ev[k]) begin n_err++; $display("FAIL basic_valid[%0d] got=%b exp=%b", k, insn_valid, ev[k]); end
            if (ev[k]) begin
                n_vec++; if (insn_pc !== ep[k]) begin n_err++; $display("FAIL basic_pc[%0d] got=%h exp=%h", k, insn_pc, ep[k]); end
                n_vec++; if (insn_data !== ed[k]) begin n_err++; $display("FAIL basic_data[%0d] got=%h exp=%h", k, insn_data, ed[k]); end
            end
        end
    endtask

    task automatic test_stall();
        int issues;
        bit found;
        apply_reset();
        insn_ready = 1'b0;
        HRESET = 1'b0;
        issues = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (HTRANS !== T_IDLE) issues++;
            if (k >= 3) begin
                n_vec++;
                if (insn_valid !== 1'b1 || insn_pc !== 17'd0 || insn_data !== 16'h2211) begin
                    n_err++; $display("FAIL stall_head[%0d] got=%b/%h/%h exp=1/0/2211", k, insn_valid, insn_pc, insn_data);
                end
            end
        end
        n_vec++; if (issues != 4) begin n_err++; $display("FAIL stall_issues got=%0d exp=4", issues); end
        n_vec++; if (HTRANS !== T_IDLE) begin n_err++; $display("FAIL stall_idle got=%b exp=00", HTRANS); end
        insn_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            tick();
            if (HTRANS !== T_IDLE) found = 1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL stall_resume got=timeout exp=issue"); end
        n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== 17'd4) begin
            n_err++; $display("FAIL stall_resume_bus got=%b@%h exp=10@00004", HTRANS, HADDR);
        end
    endtask

    // Collect up to n delivered instructions (ready held high) and compare to the expected PCs.
    task automatic expect_stream(input string name, input logic [16:0] pc0, input int n);
        int got;
        logic [16:0] pc;
        got = 0;
        pc = pc0;
        for (int c = 0; c < 20 && got < n; c++) begin
            if (insn_valid === 1'b1) begin
                n_vec++; if (insn_pc !== pc) begin n_err++; $display("FAIL %s_pc[%0d] got=%h exp=%h", name, got, insn_pc, pc); end
                n_vec++; if (insn_data !== exp_word(pc)) begin n_err++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, got, insn_data, exp_word(pc)); end
                pc = pc + 17'd2;
                got++;
            end
            tick();
        end
        n_vec++; if (got != n) begin n_err++; $display("FAIL %s_count got=%0d exp=%0d", name, got, n); end
    endtask

    task automatic test_redirect();
        apply_reset();
        insn_ready = 1'b1;
        HRESET = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 17'h00040;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got=%b exp=0", insn_valid); end
        n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== 17'h40) begin
            n_err++; $display("FAIL redir_bus got=%b@%h exp=10@00040", HTRANS, HADDR);
        end
        expect_stream("redir", 17'h00040, 2);
    endtask

    task automatic test_wrap();
        logic [16:0] ea [4];
        logic [1:0]  et [4];
        ea = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        et = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 17'h1FFFE;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_vec++; if (HTRANS !== et[k] || HADDR !== ea[k]) begin
                n_err++; $display("FAIL wrap_bus[%0d] got=%b@%h exp=%b@%h", k, HTRANS, HADDR, et[k], ea[k]);
            end
        end
        expect_stream("wrap", 17'h1FFFE, 2);
    endtask

    task automatic test_reset_mid();
        insn_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        HRESET = 1'b1;
        tick();
        n_vec++; if (HTRANS !== T_IDLE || HADDR !== 17'd0) begin n_err++; $display("FAIL rstmid_bus got=%b@%h exp=00@00000", HTRANS, HADDR); end
        n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", insn_valid); end
        n_vec++; if (align_fault !== 1'b0) begin n_err++; $display("FAIL rstmid_fault got=%b exp=0", align_fault); end
        HRESET = 1'b0;
        tick();
        n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== 17'd0) begin n_err++; $display("FAIL rstmid_restart got=%b@%h exp=10@00000", HTRANS, HADDR); end
        expect_stream("rstmid", 17'h00000, 2);
    endtask

    task automatic test_back_to_back();
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 17'h00100;
        tick();
        redirect_pc = 17'h00200;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== 17'h200) begin n_err++; $display("FAIL b2b_bus got=%b@%h exp=10@00200", HTRANS, HADDR); end
        n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid got=%b exp=0", insn_valid); end
        expect_stream("b2b", 17'h00200, 2);
    endtask

    task automatic test_align();
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 17'h00041;
        tick();
        redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (align_fault !== 1'b1 || HTRANS !== T_IDLE || insn_valid !== 1'b0) begin
                n_err++; $display("FAIL align_halt[%0d] got=%b/%b/%b exp=1/00/0", k, align_fault, HTRANS, insn_valid);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 17'h00042;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (align_fault !== 1'b0) begin n_err++; $display("FAIL align_clear got=%b exp=0", align_fault); end
        n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== 17'h42) begin n_err++; $display("FAIL align_resume got=%b@%h exp=10@00042", HTRANS, HADDR); end
        expect_stream("align", 17'h00042, 2);
`else
        n_vec++; if (align_fault !== 1'b0) begin n_err++; $display("FAIL align_fault got=%b exp=0", align_fault); end
        n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== 17'h41) begin n_err++; $display("FAIL align_bus got=%b@%h exp=10@00041", HTRANS, HADDR); end
        expect_stream("align", 17'h00041, 2);
`endif
    endtask

    task automatic test_random();
        logic [16:0] exp_pc, tgt, p_pc, p_addr, p_tgt;
        logic [15:0] p_data;
        logic [1:0]  p_trans;
        logic        p_valid, p_ready, p_redir, rdy, rd;
        int issued, popped, total;
        exp_pc = '0; issued = 0; popped = 0; total = 0;
        for (int i = 0; i < 800; i++) begin
            rd  = (i == 0) || ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? (17'h1FFFA + 17'(2 * $urandom_range(0, 2)))
                                              : {16'($urandom_range(0, 65535)), 1'b0};
            rdy = ($urandom_range(0, 3) != 0);
            if (insn_valid === 1'b1 && rdy && i > 0) begin
                n_vec++; if (insn_pc !== exp_pc || insn_data !== exp_word(exp_pc)) begin
                    n_err++; $display("FAIL rand_pop[%0d] got=%h/%h exp=%h/%h", i, insn_pc, insn_data, exp_pc, exp_word(exp_pc));
                end
                exp_pc = exp_pc + 17'd2;
                popped++;
                total++;
            end
            if (rd) begin exp_pc = tgt; issued = 0; popped = 0; end
            p_valid = insn_valid; p_ready = rdy; p_redir = rd; p_tgt = tgt;
            p_pc = insn_pc; p_data = insn_data; p_trans = HTRANS; p_addr = HADDR;
            redirect_valid = rd; redirect_pc = tgt; insn_ready = rdy;
            tick();
            if (p_redir) begin
                n_vec++; if (HTRANS !== T_NONSEQ || HADDR !== p_tgt || insn_valid !== 1'b0) begin
                    n_err++; $display("FAIL rand_redir[%0d] got=%b@%h v%b exp=10@%h v0", i, HTRANS, HADDR, insn_valid, p_tgt);
                end
                issued = 1;
            end else begin
                n_vec++;
                if (HTRANS === T_IDLE) begin
                    if (HADDR !== p_addr) begin n_err++; $display("FAIL rand_idle_hold[%0d] got=%h exp=%h", i, HADDR, p_addr); end
                end else if (HTRANS === T_SEQ) begin
                    if (p_trans === T_IDLE || HADDR !== 17'(p_addr + 17'd1)) begin
                        n_err++; $display("FAIL rand_seq[%0d] got=%h prev=%b@%h exp=active@%h", i, HADDR, p_trans, p_addr, 17'(p_addr + 17'd1));
                    end
                end else if (HTRANS === T_NONSEQ) begin
                    if (p_trans !== T_IDLE || HADDR !== 17'(p_addr + 17'd1)) begin
                        n_err++; $display("FAIL rand_nonseq[%0d] got=%h prev=%b@%h exp=00@%h", i, HADDR, p_trans, p_addr, 17'(p_addr + 17'd1));
                    end
                end else begin
                    n_err++; $display("FAIL rand_htrans[%0d] got=%b exp=00/10/11", i, HTRANS);
                end
                if (HTRANS !== T_IDLE) issued++;
                if (p_valid && !p_ready) begin
                    n_vec++; if (insn_valid !== 1'b1 || insn_pc !== p_pc || insn_data !== p_data) begin
                        n_err++; $display("FAIL rand_hold[%0d] got=%b/%h/%h exp=1/%h/%h", i, insn_valid, insn_pc, insn_data, p_pc, p_data);
                    end
                end
            end
            n_vec++; if (((issued + 1) / 2) - popped > FIFO_DEPTH) begin
                n_err++; $display("FAIL rand_credit[%0d] got=%0d exp<=%0d", i, ((issued + 1) / 2) - popped, FIFO_DEPTH);
            end
        end
        redirect_valid = 1'b0;
        n_vec++; if (total < 50) begin n_err++; $display("FAIL rand_progress got=%0d exp>=50", total); end
    endtask

    initial begin
        for (int a = 0; a < 131072; a++) iram[a] = 8'($urandom);
        iram[0] = 8'h11; iram[1] = 8'h22; iram[2] = 8'h33; iram[3] = 8'h44;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_align();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
